// File: rtl/bconv_sched.sv
// bconv_sched: frame/row/pass scheduler for a binary-weight convolution datapath.
//
// For each frame it emits one VSYNC. Each of the SIZE rows then gets one HSYNC
// and CHANNEL passes. A pass loads NBEAT weight beats from the ROM, pulses
// REUSE, and then streams SIZE valid pixels. GAP idle cycles follow each pass.
//
// Ports
//   i_sclk        clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       frame start pulse; only looked at while idle
//   i_src_rdy     line-buffer pixel available; becomes o_valid during STREAM
//   o_busy        high whenever the scheduler is not idle
//   o_done        one-cycle end-of-frame pulse
//   o_wrom_rd     weight ROM read enable (ROM read latency is one cycle)
//   o_wrom_addr   weight ROM address, pass*NBEAT + beat
//   i_wrom_data   weight ROM read data
//   o_vsync       one-cycle frame-start framing pulse
//   o_hsync       one-cycle row-start framing pulse
//   o_reuse       one-cycle pass-start framing pulse
//   o_valid       pixel-valid strobe
//   o_weight_vld  o_wrom_rd delayed by one cycle
//   o_weight      ROM data while o_weight_vld is high, otherwise zero
//
// Build option
//   BCONV_SCHED_PREFETCH_EN  fetches the weights for pass c+1 during the STREAM
//                            of pass c. Passes 1..CHANNEL-1 of each row then go
//                            straight to REUSE. This option needs SIZE >= NBEAT+1.
//
// state  | meaning
// IDLE   | waiting for i_start
// VSYNC  | frame framing pulse
// HSYNC  | row framing pulse
// LOAD   | NBEAT weight ROM reads for the current pass
// LAT    | last ROM beat arriving at the datapath
// REUSE  | pass framing pulse
// STREAM | o_valid follows i_src_rdy until SIZE pixels have been sent
// GAP    | idle cycles after a pass (also waits for an unfinished prefetch)
// DONE   | end-of-frame pulse
module bconv_sched #(
    parameter int CHANNEL = 128,
    parameter int BATCH   = 8,
    parameter int WIDTH_W = 18,
    parameter int SIZE    = 28,
    parameter int GAP     = 0,
    parameter int ADDR_W  = 12
) (
    input  logic                       i_sclk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_src_rdy,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_wrom_rd,
    output logic [ADDR_W-1:0]          o_wrom_addr,
    input  logic [WIDTH_W*BATCH-1:0]   i_wrom_data,
    output logic                       o_vsync,
    output logic                       o_hsync,
    output logic                       o_reuse,
    output logic                       o_valid,
    output logic                       o_weight_vld,
    output logic [WIDTH_W*BATCH-1:0]   o_weight
);
    localparam int NBEAT = CHANNEL / BATCH;
    localparam int CW    = $clog2(CHANNEL + 1);
    localparam int RW    = $clog2(SIZE + 1);
    localparam int BW    = $clog2(NBEAT + 1);
    localparam int GW    = $clog2(GAP + 2);
    localparam logic [CW-1:0] C_LAST = CW'(CHANNEL - 1);
    localparam logic [RW-1:0] R_LAST = RW'(SIZE - 1);
    localparam logic [RW-1:0] V_LOAD = RW'(SIZE);
    localparam logic [BW-1:0] B_LAST = BW'(NBEAT - 1);
    localparam logic [GW-1:0] G_LOAD = GW'(GAP);

    typedef enum logic [3:0] {
        S_IDLE, S_VSYNC, S_HSYNC, S_LOAD, S_LAT, S_REUSE, S_STREAM, S_GAP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     c_q, c_d;
    logic [RW-1:0]     row_q, row_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [RW-1:0]     vcnt_q, vcnt_d;    // valid pixels still owed in this pass
    logic [GW-1:0]     gcnt_q, gcnt_d;    // gap cycles still owed
    logic              wvld_q;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              pass_end;
`ifdef BCONV_SCHED_PREFETCH_EN
    localparam logic [BW-1:0] B_NUM = BW'(NBEAT);
    logic              pf_act_q, pf_act_d;
    logic [BW-1:0]     pf_cnt_q, pf_cnt_d;   // 0..NBEAT-1 reads, NBEAT = latency cycle
    logic              pf_done_q, pf_done_d;
    logic              pf_ready;
`endif

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            c_q       <= '0;
            row_q     <= '0;
            beat_q    <= '0;
            vcnt_q    <= '0;
            gcnt_q    <= '0;
            wvld_q    <= 1'b0;
`ifdef BCONV_SCHED_PREFETCH_EN
            pf_act_q  <= 1'b0;
            pf_cnt_q  <= '0;
            pf_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            row_q     <= row_d;
            beat_q    <= beat_d;
            vcnt_q    <= vcnt_d;
            gcnt_q    <= gcnt_d;
            wvld_q    <= rd;
`ifdef BCONV_SCHED_PREFETCH_EN
            pf_act_q  <= pf_act_d;
            pf_cnt_q  <= pf_cnt_d;
            pf_done_q <= pf_done_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        row_d    = row_q;
        beat_d   = beat_q;
        vcnt_d   = vcnt_q;
        gcnt_d   = gcnt_q;
        rd       = 1'b0;
        addr     = '0;
        o_vsync  = 1'b0;
        o_hsync  = 1'b0;
        o_reuse  = 1'b0;
        o_valid  = 1'b0;
        o_done   = 1'b0;
        pass_end = 1'b0;
`ifdef BCONV_SCHED_PREFETCH_EN
        pf_act_d  = pf_act_q;
        pf_cnt_d  = pf_cnt_q;
        pf_done_d = pf_done_q;
        // The prefetch counts as complete during its own latency cycle.
        pf_ready  = pf_done_q | (pf_act_q & (pf_cnt_q == B_NUM));
        // The prefetch runs on its own timeline and ignores i_src_rdy stalls.
        if (pf_act_q) begin
            if (pf_cnt_q == B_NUM) begin
                pf_act_d  = 1'b0;
                pf_done_d = 1'b1;
            end else begin
                rd       = 1'b1;
                addr     = (ADDR_W'(c_q) + ADDR_W'(1)) * ADDR_W'(NBEAT) + ADDR_W'(pf_cnt_q);
                pf_cnt_d = pf_cnt_q + 1'b1;
            end
        end
`endif
        unique case (state_q)
            S_IDLE:   if (i_start) state_d = S_VSYNC;
            S_VSYNC: begin
                o_vsync = 1'b1;
                state_d = S_HSYNC;
            end
            S_HSYNC: begin
                o_hsync = 1'b1;
                beat_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                rd   = 1'b1;
                addr = ADDR_W'(c_q) * ADDR_W'(NBEAT) + ADDR_W'(beat_q);
                if (beat_q == B_LAST) begin
                    beat_d  = '0;
                    state_d = S_LAT;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_LAT:    state_d = S_REUSE;
            S_REUSE: begin
                o_reuse = 1'b1;
                vcnt_d  = V_LOAD;
                state_d = S_STREAM;
`ifdef BCONV_SCHED_PREFETCH_EN
                if (c_q != C_LAST) begin
                    pf_act_d  = 1'b1;
                    pf_cnt_d  = '0;
                    pf_done_d = 1'b0;
                end
`endif
            end
            S_STREAM: begin
                o_valid = i_src_rdy;
                if (i_src_rdy) begin
                    vcnt_d = vcnt_q - 1'b1;
                    if (vcnt_q == RW'(1)) begin
                        gcnt_d = G_LOAD;
                        if (GAP == 0) pass_end = 1'b1;
                        else          state_d  = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q != '0) gcnt_d = gcnt_q - 1'b1;
                if (gcnt_q <= GW'(1)) pass_end = 1'b1;
            end
            S_DONE: begin
                o_done  = 1'b1;
                c_d     = '0;
                row_d   = '0;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase

        if (pass_end) begin
            if (c_q != C_LAST) begin
`ifdef BCONV_SCHED_PREFETCH_EN
                // Wait in GAP until the next pass's weights have landed.
                if (pf_ready) begin
                    c_d       = c_q + 1'b1;
                    pf_act_d  = 1'b0;
                    pf_done_d = 1'b0;
                    state_d   = S_REUSE;
                end else begin
                    state_d   = S_GAP;
                end
`else
                c_d     = c_q + 1'b1;
                beat_d  = '0;
                state_d = S_LOAD;
`endif
            end else if (row_q != R_LAST) begin
                row_d   = row_q + 1'b1;
                c_d     = '0;
                state_d = S_HSYNC;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_wrom_rd    = rd;
    assign o_wrom_addr  = addr;
    assign o_weight_vld = wvld_q;
    assign o_weight     = wvld_q ? i_wrom_data : '0;

endmodule
